// File: rtl/lic_mmio.sv
// lic_mmio: memory-mapped register window onto the local interrupt/timer
// controller (LIC). One request in flight at a time: a request is accepted in
// IDLE, and its response is held in RESP until the consumer takes it.
//
// Register map (byte offsets):
//   0x0 mtime     RW  forwarded to/from the LIC
//   0x4 mtimecmp  RW  forwarded to/from the LIC; a store also rearms (clears pending)
//   0x8 STATUS    bit0 = timer pending, write-1-to-clear
//   0xC MSIP      bit0 = msip, only when LIC_MMIO_MSIP_EN is defined, else error
// Misaligned, unmapped or out-of-block (bits ADDR_W-1:4 set) offsets answer
// resp_err=1 with zero data and have no side effect.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   req_*                          request channel (valid/ready)
//   resp_*                         response channel (valid/ready)
//   lic_mtime_read/_write/_ena     mtime value and write strobe
//   lic_mtimecmp_read/_write/_ena  mtimecmp value and write strobe
//   lic_timer_interrupt            one-cycle compare-match pulse
//   timer_irq                      level pending flag to the core
//   msip_irq                       software interrupt level (LIC_MMIO_MSIP_EN only)
//
// Configuration macro: LIC_MMIO_MSIP_EN (enables the MSIP register at 0xC).

`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif

module lic_mmio #(
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [`CPU6_XLEN-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [`CPU6_XLEN-1:0] resp_rdata,
  output logic                  resp_err,
  input  logic [`CPU6_XLEN-1:0] lic_mtime_read,
  input  logic [`CPU6_XLEN-1:0] lic_mtimecmp_read,
  output logic [`CPU6_XLEN-1:0] lic_mtime_write,
  output logic [`CPU6_XLEN-1:0] lic_mtimecmp_write,
  output logic                  lic_mtime_write_ena,
  output logic                  lic_mtimecmp_write_ena,
  input  logic                  lic_timer_interrupt,
`ifdef LIC_MMIO_MSIP_EN
  output logic                  msip_irq,
`endif
  output logic                  timer_irq
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t                  state;
  logic                    pending;
  logic                    accept;
  logic                    wr_ok;
  logic [3:0]              off;
  logic                    hi_err;
  logic                    dec_err;
  logic                    msip_hit;
  logic [`CPU6_XLEN-1:0]   load_data;
  logic                    status_clr;
  logic                    rearm;

`ifdef LIC_MMIO_MSIP_EN
  logic msip;
  assign msip_irq = msip;
  assign msip_hit = 1'b1;
`else
  assign msip_hit = 1'b0;
`endif

  assign off    = req_addr[3:0];
  assign hi_err = (req_addr >> 4) != '0;
  // Aligned in-block offsets are 0x0/0x4/0x8/0xC; 0xC only exists with MSIP.
  assign dec_err = (off[1:0] != 2'b00) || hi_err || ((off == 4'hC) && !msip_hit);

  assign accept = req_valid && req_ready;
  // Side effects only for accepted, well-formed stores outside reset.
  assign wr_ok  = accept && req_write && !dec_err && !reset;

  assign lic_mtime_write        = req_wdata;
  assign lic_mtimecmp_write     = req_wdata;
  assign lic_mtime_write_ena    = wr_ok && (off == 4'h0);
  assign lic_mtimecmp_write_ena = wr_ok && (off == 4'h4);

  assign status_clr = wr_ok && (off == 4'h8) && req_wdata[0];
  assign rearm      = wr_ok && (off == 4'h4);

  assign timer_irq = pending;

  // Load data uses the pre-update pending/msip values of the accept cycle.
  always_comb begin
    load_data = '0;
    if (!req_write && !dec_err) begin
      case (off)
        4'h0:    load_data = lic_mtime_read;
        4'h4:    load_data = lic_mtimecmp_read;
        4'h8:    load_data = {{(`CPU6_XLEN-1){1'b0}}, pending};
`ifdef LIC_MMIO_MSIP_EN
        4'hC:    load_data = {{(`CPU6_XLEN-1){1'b0}}, msip};
`endif
        default: load_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      pending    <= 1'b0;
`ifdef LIC_MMIO_MSIP_EN
      msip       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          state      <= RESP;
          req_ready  <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= load_data;
          resp_err   <= dec_err;
        end
        RESP: if (resp_ready) begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase

      // A compare-match pulse wins over any same-cycle clear.
      if (lic_timer_interrupt)
        pending <= 1'b1;
      else if (status_clr || rearm)
        pending <= 1'b0;

`ifdef LIC_MMIO_MSIP_EN
      if (wr_ok && (off == 4'hC))
        msip <= req_wdata[0];
`endif
    end
  end

endmodule

// File: tb/tb_lic_mmio.sv
`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif

module tb_lic_mmio;
  localparam int AW = 5;
  localparam int XL = `CPU6_XLEN;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [XL-1:0] req_wdata;
  logic          resp_valid, resp_ready, resp_err;
  logic [XL-1:0] resp_rdata;
  logic [XL-1:0] lic_mtime_read, lic_mtimecmp_read;
  logic [XL-1:0] lic_mtime_write, lic_mtimecmp_write;
  logic          lic_mtime_write_ena, lic_mtimecmp_write_ena;
  logic          lic_timer_interrupt, timer_irq;
`ifdef LIC_MMIO_MSIP_EN
  logic          msip_irq;
  localparam bit MSIP_ON = 1'b1;
`else
  localparam bit MSIP_ON = 1'b0;
`endif

  lic_mmio #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .lic_mtime_read(lic_mtime_read), .lic_mtimecmp_read(lic_mtimecmp_read),
    .lic_mtime_write(lic_mtime_write), .lic_mtimecmp_write(lic_mtimecmp_write),
    .lic_mtime_write_ena(lic_mtime_write_ena),
    .lic_mtimecmp_write_ena(lic_mtimecmp_write_ena),
    .lic_timer_interrupt(lic_timer_interrupt),
`ifdef LIC_MMIO_MSIP_EN
    .msip_irq(msip_irq),
`endif
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected responses: {err, rdata}
  logic [XL:0] sb_q[$];

  // Reference model state
  bit m_busy, m_pend, m_msip;

  task automatic chk(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_err(input int a);
    return (a % 4 != 0) || (a >= 16) || (a == 12 && !MSIP_ON);
  endfunction

  // One bus cycle: drive inputs after the edge, check mid-cycle, advance model.
  task automatic cycle(input bit v, input bit w, input int a, input logic [XL-1:0] d,
                       input bit irq, input bit rr, input bit rst,
                       input logic [XL-1:0] mt, input logic [XL-1:0] mc);
    bit acc, err, clr;
    logic [XL-1:0] rd;
    @(posedge clk); #1;
    reset = rst; req_valid = v; req_write = w; req_addr = AW'(a); req_wdata = d;
    lic_timer_interrupt = irq; resp_ready = rr;
    lic_mtime_read = mt; lic_mtimecmp_read = mc;
    @(negedge clk);
    if (rst) begin
      chk("rst_mtime_ena", {31'b0, lic_mtime_write_ena}, 0);
      chk("rst_mtimecmp_ena", {31'b0, lic_mtimecmp_write_ena}, 0);
      m_busy = 0; m_pend = 0; m_msip = 0;
      sb_q.delete();
      return;
    end
    chk("req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
    chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_busy});
    chk("timer_irq", {31'b0, timer_irq}, {31'b0, m_pend});
    acc = v && !m_busy;
    err = addr_err(a);
    chk("mtime_ena", {31'b0, lic_mtime_write_ena}, {31'b0, acc && w && !err && a == 0});
    chk("mtimecmp_ena", {31'b0, lic_mtimecmp_write_ena}, {31'b0, acc && w && !err && a == 4});
    if (acc && w && !err && a == 0) chk("mtime_wbus", lic_mtime_write, d);
    if (acc && w && !err && a == 4) chk("mtimecmp_wbus", lic_mtimecmp_write, d);
    if (acc) begin
      rd = 0;
      if (!w && !err) begin
        if (a == 0)       rd = mt;
        else if (a == 4)  rd = mc;
        else if (a == 8)  rd = XL'(m_pend);
        else if (a == 12) rd = XL'(m_msip);
      end
      sb_q.push_back({err, rd});
    end
    clr = acc && w && !err && (a == 4 || (a == 8 && d[0]));
    if (irq) m_pend = 1;
    else if (clr) m_pend = 0;
    if (acc && w && !err && a == 12) m_msip = d[0];
    if (m_busy) m_busy = !rr;
    else        m_busy = acc;
  endtask

  // Scoreboard monitor: a presented response must match the oldest expectation
  // every cycle it is held, and is retired when consumed.
  always @(negedge clk) begin
    if (!reset && resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected: got err=%0b data=0x%0h expected no response", resp_err, resp_rdata);
      end else begin
        chk("resp_rdata", resp_rdata, sb_q[0][XL-1:0]);
        chk("resp_err", {31'b0, resp_err}, {31'b0, sb_q[0][XL]});
        if (resp_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    resp_ready = 0; lic_timer_interrupt = 0; lic_mtime_read = 0; lic_mtimecmp_read = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", {31'b0, req_ready}, 1);
    chk("reset_resp_valid", {31'b0, resp_valid}, 0);
    chk("reset_rdata", resp_rdata, 0);
    chk("reset_err", {31'b0, resp_err}, 0);
    chk("reset_timer_irq", {31'b0, timer_irq}, 0);
    m_busy = 0; m_pend = 0; m_msip = 0;

    // Directed: load mtime, store mtimecmp
    cycle(1, 0, 0, 0, 0, 1, 0, 32'h1234, 32'h55);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    cycle(1, 1, 4, 32'h100, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Interrupt pulse, read status, W1C clear
    cycle(0, 0, 0, 0, 1, 1, 0, 0, 0);
    cycle(1, 0, 8, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    cycle(1, 1, 8, 1, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Clear colliding with a new pulse: pulse wins
    cycle(0, 0, 0, 0, 1, 1, 0, 0, 0);
    cycle(1, 1, 8, 1, 1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Rearm via mtimecmp store
    cycle(1, 1, 4, 32'h200, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Error decodes
    cycle(1, 0, 2, 0, 0, 1, 0, 32'hdead, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 16, 0, 0, 1, 0, 32'hbeef, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    cycle(1, 1, 16, 32'h7, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 12, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Backpressure then reset during RESP
    cycle(1, 0, 0, 0, 0, 0, 0, 32'hcafe, 0);
    cycle(1, 0, 4, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 32'h9, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int a;
      a = ($urandom % 4 == 0) ? int'($urandom % 32) : int'(($urandom % 4) * 4);
      cycle($urandom % 2, $urandom % 2, a, $urandom, ($urandom % 8) == 0,
            ($urandom % 4) != 0, ($urandom % 97) == 0, $urandom, $urandom);
    end

    // Drain and confirm nothing was left unanswered
    repeat (4) cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
